// File: rtl/pn_chk.sv
// pn_chk: receive-side checker for the 4-bit m-sequence y[n+4] = y[n+3] ^ y[n].
// Self-synchronises to the incoming stream, declares lock after LOCK_CNT
// consecutive correct predictions, then flywheels a local copy and flags errors.
// Too many errors in one WIN-bit window drop the checker back to search.
//
// Optional feature macro: PN_ERR_CNT_EN (adds err_clr / err_cnt saturating counter).
//
// Ports:
//   clk      in   system clock, all updates on posedge
//   res      in   synchronous active-low reset
//   din      in   serial PN bit
//   din_vld  in   din qualifier
//   locked   out  registered, 1 while locked
//   err      out  registered one-cycle pulse on a mismatched bit while locked
//   err_clr  in   clear of err_cnt (PN_ERR_CNT_EN only)
//   err_cnt  out  saturating error count (PN_ERR_CNT_EN only)
module pn_chk #(
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned WIN      = 15,
    parameter int unsigned LOSS_THR = 3
`ifdef PN_ERR_CNT_EN
    ,
    parameter int unsigned ERR_W    = 16
`endif
) (
    input  logic             clk,
    input  logic             res,
    input  logic             din,
    input  logic             din_vld,
`ifdef PN_ERR_CNT_EN
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt,
`endif
    output logic             locked,
    output logic             err
);

    localparam int unsigned FILL_W  = 3;
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = $clog2(WIN + 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         h_q, h_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]   win_err_q, win_err_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic               exp_bit;
    logic               mis;
`ifdef PN_ERR_CNT_EN
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
`endif

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        err_d     = 1'b0;
        exp_bit   = h_q[3] ^ h_q[0];
        mis       = din ^ exp_bit;

        if (din_vld) begin
            case (state_q)
                ST_SEARCH: begin
                    h_d = {din, h_q[3:1]};
                    if (fill_q < FILL_W'(4)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if (!mis && (h_q != 4'b0000)) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            match_d   = MATCH_W'(LOCK_CNT);
                            state_d   = ST_LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else if (match_q != MATCH_W'(LOCK_CNT)) begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        // mismatch or all-zero history: restart the match run
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // flywheel: local prediction, not din, feeds the history
                    h_d   = {exp_bit, h_q[3:1]};
                    err_d = mis;
                    if (mis && (win_err_q >= WIN_W'(LOSS_THR - 1))) begin
                        state_d   = ST_SEARCH;
                        h_d       = 4'b0000;
                        fill_d    = '0;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WIN_W'(WIN - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        if (mis) begin
                            win_err_d = win_err_q + WIN_W'(1);
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);

`ifdef PN_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
`endif
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q   <= ST_SEARCH;
            h_q       <= 4'b0000;
            fill_q    <= '0;
            match_q   <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef PN_ERR_CNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
`ifdef PN_ERR_CNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign locked = locked_q;
    assign err    = err_q;
`ifdef PN_ERR_CNT_EN
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pn_chk.sv
// tb_pn_chk: directed bench for pn_chk with a reference model feeding a
// scoreboard queue, plus directed checks on lock latency, error pulses,
// loss of lock and relock.
module tb_pn_chk;

    localparam int unsigned ERR_W = 16;

    logic clk;
    logic res;
    logic din;
    logic din_vld;
    logic locked;
    logic err;
`ifdef PN_ERR_CNT_EN
    logic             err_clr;
    logic [ERR_W-1:0] err_cnt;
    logic [ERR_W-1:0] obs_cnt;
`endif

    pn_chk dut (
        .clk     (clk),
        .res     (res),
        .din     (din),
        .din_vld (din_vld),
`ifdef PN_ERR_CNT_EN
        .err_clr (err_clr),
        .err_cnt (err_cnt),
`endif
        .locked  (locked),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic locked;
        logic err;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;

    // one period of the generator from seed 1111
    bit pn_tab [15] = '{1,1,1,1,0,1,0,1,1,0,0,1,0,0,0};
    int gen_idx = 0;

    // reference model state
    int         m_state = 0;
    int         m_fill  = 0;
    int         m_match = 0;
    int         m_wc    = 0;
    int         m_we    = 0;
    int         m_cnt   = 0;
    logic [3:0] m_h     = 4'b0000;
    logic       m_err   = 1'b0;

    logic obs_locked;
    logic obs_err;

    function automatic bit next_pn();
        bit b;
        b = pn_tab[gen_idx];
        gen_idx = (gen_idx == 14) ? 0 : gen_idx + 1;
        return b;
    endfunction

    task automatic model_step(input logic d, input logic v, input logic clr, input logic r);
        logic e;
        if (!r) begin
            m_state = 0; m_fill = 0; m_match = 0; m_wc = 0; m_we = 0;
            m_cnt = 0; m_h = 4'b0000; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (v) begin
                e = m_h[3] ^ m_h[0];
                if (m_state == 0) begin
                    if (m_fill < 4)                 m_fill++;
                    else if (d == e && m_h != 4'b0) m_match++;
                    else                            m_match = 0;
                    m_h = {d, m_h[3:1]};
                    if (m_match >= 8) begin
                        m_state = 1; m_wc = 0; m_we = 0;
                    end
                end else begin
                    m_h = {e, m_h[3:1]};
                    if (d != e) begin
                        m_err = 1'b1;
                        m_we++;
                    end
                    if (m_err && m_we >= 3) begin
                        m_state = 0; m_fill = 0; m_match = 0;
                        m_h = 4'b0000; m_wc = 0; m_we = 0;
                    end else begin
                        m_wc++;
                        if (m_wc == 15) begin
                            m_wc = 0; m_we = 0;
                        end
                    end
                end
            end
            if (clr)                          m_cnt = 0;
            else if (m_err && m_cnt < 65535)  m_cnt++;
        end
    endtask

    // drive one clock of stimulus, score the DUT response against the model
    task automatic do_cycle(input logic d, input logic v, input logic clr, input logic r);
        exp_t e;
        din     = d;
        din_vld = v;
        res     = r;
`ifdef PN_ERR_CNT_EN
        err_clr = clr;
`endif
        model_step(d, v, clr, r);
        e.locked = (m_state == 1);
        e.err    = m_err;
        e.cnt    = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        obs_locked = locked;
        obs_err    = err;
        vectors++;
        assert (locked === e.locked) else begin
            miscompares++;
            $error("FAIL sb_locked: got %0b expected %0b at %0t", locked, e.locked, $time);
        end
        vectors++;
        assert (err === e.err) else begin
            miscompares++;
            $error("FAIL sb_err: got %0b expected %0b at %0t", err, e.err, $time);
        end
`ifdef PN_ERR_CNT_EN
        obs_cnt = err_cnt;
        vectors++;
        assert (err_cnt === ERR_W'(e.cnt)) else begin
            miscompares++;
            $error("FAIL sb_err_cnt: got %0d expected %0d at %0t", err_cnt, e.cnt, $time);
        end
`endif
    endtask

    task automatic send(input logic inv);
        do_cycle(next_pn() ^ inv, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic check(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    initial begin
        int n;
        int errs;
        int lk;
        int vb;
        din = 1'b0; din_vld = 1'b0; res = 1'b0;
`ifdef PN_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        // reset
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_locked", int'(obs_locked), 0);
        check("rst_err", int'(obs_err), 0);

        // 1: clean stream, lock after 12th valid bit
        for (int i = 1; i <= 11; i++) begin
            send(1'b0);
            check("t1_prelock", int'(obs_locked), 0);
        end
        send(1'b0);
        check("t1_lock12", int'(obs_locked), 1);
        errs = 0; lk = 0;
        for (int i = 0; i < 200; i++) begin
            send(1'b0);
            errs += int'(obs_err);
            lk   += int'(obs_locked);
        end
        check("t1_no_err", errs, 0);
        check("t1_stay_lock", lk, 200);

        // 2: single inverted bit
        errs = 0; lk = 0;
        send(1'b1);
        errs += int'(obs_err); lk += int'(obs_locked);
        for (int i = 0; i < 14; i++) begin
            send(1'b0);
            errs += int'(obs_err); lk += int'(obs_locked);
        end
        check("t2_one_err", errs, 1);
        check("t2_locked", lk, 15);
`ifdef PN_ERR_CNT_EN
        check("t2_err_cnt", int'(obs_cnt), 1);
`endif

        // 3: three errors in one window -> loss, then relock
        n = 0;
        while (m_wc != 0 && n < 20) begin
            send(1'b0);
            n++;
        end
        errs = 0;
        send(1'b1); errs += int'(obs_err);
        send(1'b0);
        send(1'b1); errs += int'(obs_err);
        check("t3_still_lock", int'(obs_locked), 1);
        send(1'b0);
        send(1'b1); errs += int'(obs_err);
        check("t3_three_err", errs, 3);
        check("t3_lost", int'(obs_locked), 0);
        n = 0;
        do begin
            send(1'b0);
            n++;
        end while (!obs_locked && n < 40);
        check("t3_relock_bits", n, 12);

        // 4: two errors in each of two windows -> stays locked
`ifdef PN_ERR_CNT_EN
        do_cycle(next_pn(), 1'b1, 1'b1, 1'b1);
`endif
        n = 0;
        while (m_wc != 0 && n < 20) begin
            send(1'b0);
            n++;
        end
        errs = 0; lk = 0;
        for (int j = 0; j < 30; j++) begin
            send((j == 1 || j == 3 || j == 16 || j == 18) ? 1'b1 : 1'b0);
            errs += int'(obs_err); lk += int'(obs_locked);
        end
        check("t4_four_err", errs, 4);
        check("t4_locked", lk, 30);
`ifdef PN_ERR_CNT_EN
        check("t4_err_cnt", int'(obs_cnt), 4);
`endif

        // 5: constant 0 then constant 1 never locks
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        lk = 0;
        for (int i = 0; i < 100; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 1'b1);
            lk += int'(obs_locked);
        end
        for (int i = 0; i < 100; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 1'b1);
            lk += int'(obs_locked);
        end
        check("t5_never_lock", lk, 0);

        // 6: din_vld toggling, lock after 12 valid bits, then mid-lock reset
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        vb = 0; n = 0;
        while (!obs_locked && n < 60) begin
            if (n % 2 == 0) begin
                send(1'b0);
                vb++;
            end else begin
                do_cycle(1'($urandom_range(1)), 1'b0, 1'b0, 1'b1);
            end
            n++;
        end
        check("t6_valid_bits", vb, 12);
        check("t6_locked", int'(obs_locked), 1);
        do_cycle(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0);
        check("t6_rst_locked", int'(obs_locked), 0);
`ifdef PN_ERR_CNT_EN
        check("t6_rst_cnt", int'(obs_cnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
